cordic_phase_nco: RTL

Phase-accumulator NCO that generates the `theta` phase word consumed by `cordic_rotation`. It sits directly upstream of the rotator, so that a constant-frequency complex mixer is `cordic_phase_nco -> cordic_rotation`. A wide accumulator integrates a frequency control word (FCW) and adds a phase offset word (POW). The sum is truncated to the rotator's `ITERATIONS+1` phase bits. FCW/POW updates use a valid/ready handshake, are double-buffered, and are applied phase-continuously at the accumulator wrap.

---
 rtl/cordic_phase_nco.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cordic_phase_nco.sv
// cordic_phase_nco: phase-accumulator NCO producing the theta word for cordic_rotation.
// FCW/POW updates arrive via valid/ready into a shadow register and are applied at the
// accumulator wrap (phase-continuous), on sync, or at once while the NCO is stopped.
// Optional feature: define CORDIC_PHASE_NCO_DITHER_EN to add LFSR dither below the
// truncation point.
module cordic_phase_nco #(
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned PHASE_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   sync,
    input  logic [ACC_WIDTH-1:0]   fcw_in,
    input  logic [ACC_WIDTH-1:0]   pow_in,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic [PHASE_WIDTH-1:0] theta,
    output logic                   theta_valid
);

    typedef enum logic [0:0] {StIdle, StPending} cfg_state_e;

    cfg_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, fcw_act_q, pow_act_q, fcw_shd_q, pow_shd_q, sum_q;
    logic [ACC_WIDTH-1:0] sum_d;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 v1_q;
    logic                 accept, apply, wrap;
    logic                 unused_sum_lo;

    // Carry out of the accumulator add marks the phase wrap.
    assign acc_sum   = {1'b0, acc_q} + {1'b0, fcw_act_q};
    assign wrap      = acc_sum[ACC_WIDTH];
    assign cfg_ready = (state_q == StIdle);
    assign accept    = cfg_valid && cfg_ready;
    assign apply     = (state_q == StPending) && (sync || (fcw_act_q == '0) || (en && wrap));

    // Bits below the truncation point only matter through the carry into the kept bits.
    assign unused_sum_lo = ^sum_q[ACC_WIDTH-PHASE_WIDTH-1:0];

`ifdef CORDIC_PHASE_NCO_DITHER_EN
    localparam int unsigned DitherShift = ACC_WIDTH - PHASE_WIDTH - 16;

    logic [15:0]          lfsr_q;
    logic [ACC_WIDTH-1:0] dither;

    assign dither = {{(ACC_WIDTH-16){1'b0}}, lfsr_q} << DitherShift;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, reseeded on sync, stepped per sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else if (sync) begin
            lfsr_q <= 16'hACE1;
        end else if (en) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Phase sum with dither injected just below the kept bits.
    always_comb begin
        sum_d = acc_q + pow_act_q + dither;
    end
`else
    // Phase sum, pure truncation downstream.
    always_comb begin
        sum_d = acc_q + pow_act_q;
    end
`endif

    // Config FSM next state: accept into shadow, then wait for a qualifying apply edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StPending;
            StPending: if (apply)  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Config state and shadow/active register transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            fcw_shd_q <= '0;
            pow_shd_q <= '0;
            fcw_act_q <= '0;
            pow_act_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                fcw_shd_q <= fcw_in;
                pow_shd_q <= pow_in;
            end
            if (apply) begin
                fcw_act_q <= fcw_shd_q;
                pow_act_q <= pow_shd_q;
            end
        end
    end

    // Accumulator and stage 1; sync wins over en. Uses the pre-apply fcw/pow on the wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sum_q <= '0;
            v1_q  <= 1'b0;
        end else if (sync) begin
            acc_q <= '0;
            v1_q  <= 1'b0;
        end else if (en) begin
            acc_q <= acc_sum[ACC_WIDTH-1:0];
            sum_q <= sum_d;
            v1_q  <= 1'b1;
        end else begin
            v1_q  <= 1'b0;
        end
    end

    // Stage 2: truncate to the rotator phase width; theta holds between samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            theta       <= '0;
            theta_valid <= 1'b0;
        end else begin
            theta_valid <= v1_q;
            if (v1_q) begin
                theta <= sum_q[ACC_WIDTH-1 -: PHASE_WIDTH];
            end
        end
    end

endmodule
